// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg
//   Shared definitions for the GPIO bus arbiter:
//   - arb_state_e      : sequencing FSM states
//   - GPIO_DATA_W      : width of the shared GPIO output register
//   - DEFAULT_NUM_REQ  : default requester count
//   - wrap_add()       : modular add for small index arithmetic that must stay
//                        correct when the modulus is not a power of two
package gpio_arb_pkg;

    localparam int GPIO_DATA_W     = 32;
    localparam int DEFAULT_NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

    // (base + off) mod n, valid for base < n and off < n.
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick: grants the first asserted request
//   at or after rr_ptr, searching circularly.
//   Ports:
//     req        in   NUM_REQ  request vector
//     rr_ptr     in   IDX_W    highest-priority index for this pick
//     grant      out  NUM_REQ  one-hot grant (all zero when no request)
//     grant_idx  out  IDX_W    index of the granted request
//     any_grant  out  1        at least one request asserted
module rr_arbiter
    import gpio_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'(wrap_add(32'(rr_ptr), 32'(i), 32'(NUM_REQ)));
            if (!any_grant && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                any_grant   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter
//   Shares one GPIO output register between NUM_REQ requesters. One request
//   is accepted at a time (round-robin), the FSM strobes the register's we/re
//   pins and returns a single-cycle response to the winner.
//   Ports:
//     clk, reset             clock; synchronous active-high reset
//     req_valid/write/wdata  per-requester request (wdata slice i*DATA_W)
//     req_ready              one-hot accept, only in IDLE
//     rsp_valid, rsp_rdata   one-cycle completion pulse and read data
//     gpio_we/re/wdata       strobes and data to the GPIO register
//     gpio_rdata             registered GPIO read data (cycle after gpio_re)
//     busy                   high outside IDLE
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a request; req_ready follows the arbiter
//   ISSUE   | gpio_we (write) or gpio_re (read) strobed for one cycle
//   CAPTURE | read only: gpio_rdata latched at the closing edge
//   RESP    | rsp_valid to the winner; rr_ptr advances past the winner
module gpio_bus_arbiter
    import gpio_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    parameter  int DATA_W  = GPIO_DATA_W,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      gpio_we,
    output logic                      gpio_re,
    output logic [DATA_W-1:0]         gpio_wdata,
    input  logic [DATA_W-1:0]         gpio_rdata,
    output logic                      busy
);

    arb_state_e          state_q,      state_d;
    logic [IDX_W-1:0]    rr_ptr_q,     rr_ptr_d;
    logic [IDX_W-1:0]    win_idx_q,    win_idx_d;
    logic                win_write_q,  win_write_d;
    logic                gpio_we_q,    gpio_we_d;
    logic                gpio_re_q,    gpio_re_d;
    logic [DATA_W-1:0]   gpio_wdata_q, gpio_wdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q,  rsp_rdata_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                any_grant;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;
    logic [NUM_REQ-1:0]  win_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // Grant is one-hot, so an AND-OR mux picks the winner's data and type.
    always_comb begin
        sel_wdata  = '0;
        sel_write  = |(grant & req_write);
        win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
            end
            win_onehot[i] = (win_idx_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        win_idx_d    = win_idx_q;
        win_write_d  = win_write_q;
        gpio_we_d    = 1'b0;
        gpio_re_d    = 1'b0;
        gpio_wdata_d = '0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                rsp_rdata_d = '0;
                if (any_grant) begin
                    win_idx_d   = grant_idx;
                    win_write_d = sel_write;
                    state_d     = ST_ISSUE;
                    if (sel_write) begin
                        gpio_we_d    = 1'b1;
                        gpio_wdata_d = sel_wdata;
                    end else begin
                        gpio_re_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (win_write_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = win_onehot;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                rsp_rdata_d = gpio_rdata;
                rsp_valid_d = win_onehot;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // Explicit wrap keeps the pointer legal for non-power-of-2 NUM_REQ.
                rr_ptr_d    = IDX_W'(wrap_add(32'(win_idx_q), 32'd1, 32'(NUM_REQ)));
                rsp_rdata_d = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            win_idx_q    <= '0;
            win_write_q  <= 1'b0;
            gpio_we_q    <= 1'b0;
            gpio_re_q    <= 1'b0;
            gpio_wdata_q <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            win_idx_q    <= win_idx_d;
            win_write_q  <= win_write_d;
            gpio_we_q    <= gpio_we_d;
            gpio_re_q    <= gpio_re_d;
            gpio_wdata_q <= gpio_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) ? grant : '0;
    assign busy       = (state_q != ST_IDLE);
    assign gpio_we    = gpio_we_q;
    assign gpio_re    = gpio_re_q;
    assign gpio_wdata = gpio_wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
module tb_gpio_bus_arbiter;

    typedef struct { bit write; logic [31:0] wdata; } txn_t;
    typedef struct { int idx; logic [31:0] rdata; } exp_t;
    typedef struct { int idx; bit write; int cyc; } acc_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata, gpio_wdata;
    logic [31:0] gpio_rdata = '0;
    logic [31:0] gpio_reg   = '0;
    logic        gpio_we, gpio_re, busy;

    logic        reset3;
    logic [2:0]  r3_valid, r3_write, r3_ready, r3_rsp_valid;
    logic [95:0] r3_wdata;
    logic [31:0] r3_rsp_rdata, g3_wdata;
    logic [31:0] g3_rdata = '0;
    logic        g3_we, g3_re, busy3;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int rsp_count = 0;
    int re_count = 0;
    bit re_prev = 1'b0;

    txn_t pend0_q[$];
    txn_t pend1_q[$];
    exp_t exp_q[$];
    logic [31:0] exp_w_q[$];
    acc_t acc_q[$];

    gpio_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .gpio_we(gpio_we), .gpio_re(gpio_re), .gpio_wdata(gpio_wdata),
        .gpio_rdata(gpio_rdata), .busy(busy)
    );

    gpio_bus_arbiter #(.NUM_REQ(3)) dut3 (
        .clk(clk), .reset(reset3),
        .req_valid(r3_valid), .req_write(r3_write), .req_wdata(r3_wdata),
        .req_ready(r3_ready), .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata),
        .gpio_we(g3_we), .gpio_re(g3_re), .gpio_wdata(g3_wdata),
        .gpio_rdata(g3_rdata), .busy(busy3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // GPIO register model: write lands at the edge ending ISSUE, read data
    // is registered and valid the cycle after gpio_re.
    always @(posedge clk) begin
        if (gpio_we) gpio_reg <= gpio_wdata;
        if (gpio_re) gpio_rdata <= gpio_reg;
    end

    a_ready1:  assert property (@(posedge clk) $onehot0(req_ready)) else $error("req_ready not one-hot");
    a_rsp1:    assert property (@(posedge clk) $onehot0(rsp_valid)) else $error("rsp_valid not one-hot");
    a_wr1:     assert property (@(posedge clk) !(gpio_we && gpio_re)) else $error("gpio_we and gpio_re together");
    a_busy1:   assert property (@(posedge clk) busy |-> (req_ready == 2'b00)) else $error("req_ready while busy");
    a_wd1:     assert property (@(posedge clk) !gpio_we |-> (gpio_wdata == '0)) else $error("gpio_wdata nonzero without we");
    a_ready3:  assert property (@(posedge clk) $onehot0(r3_ready)) else $error("dut3 req_ready not one-hot");
    a_rsp3:    assert property (@(posedge clk) $onehot0(r3_rsp_valid)) else $error("dut3 rsp_valid not one-hot");
    a_wr3:     assert property (@(posedge clk) !(g3_we && g3_re)) else $error("dut3 we and re together");

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic add(input int who, input bit wr, input logic [31:0] d);
        txn_t t;
        t.write = wr;
        t.wdata = d;
        if (who == 0) pend0_q.push_back(t);
        else          pend1_q.push_back(t);
    endtask

    task automatic expect_rsp(input int idx, input logic [31:0] rdata);
        exp_t e;
        e.idx   = idx;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (pend0_q.size() == 0 && pend1_q.size() == 0 && exp_q.size() == 0 &&
                acc_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_busy(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        if (!seen) check({name, "_busy_timeout"}, 64'd0, 64'd1);
    endtask

    // Requester driver: present the head of each requester's queue, pop it on handshake.
    initial begin
        logic [1:0] hs;
        int hs_cyc;
        acc_t a;
        req_valid = '0; req_write = '0; req_wdata = '0;
        forever begin
            @(negedge clk);
            req_valid = '0; req_write = '0; req_wdata = '0;
            if (pend0_q.size() > 0) begin
                req_valid[0] = 1'b1; req_write[0] = pend0_q[0].write; req_wdata[31:0] = pend0_q[0].wdata;
            end
            if (pend1_q.size() > 0) begin
                req_valid[1] = 1'b1; req_write[1] = pend1_q[0].write; req_wdata[63:32] = pend1_q[0].wdata;
            end
            #1;
            hs = req_valid & req_ready;
            hs_cyc = cyc;
            @(posedge clk);
            if (hs[0]) begin
                a.idx = 0; a.write = pend0_q[0].write; a.cyc = hs_cyc;
                acc_q.push_back(a);
                void'(pend0_q.pop_front());
            end
            if (hs[1]) begin
                a.idx = 1; a.write = pend1_q[0].write; a.cyc = hs_cyc;
                acc_q.push_back(a);
                void'(pend1_q.pop_front());
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        acc_t a2;
        if (rsp_valid != 2'b00) begin
            rsp_count++;
            if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("rsp_idx", 64'(rsp_valid), 64'd1 << e.idx);
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            end
            if (acc_q.size() > 0) begin
                a2 = acc_q.pop_front();
                check("rsp_latency", 64'(cyc - a2.cyc), a2.write ? 64'd2 : 64'd3);
            end
        end
        if (gpio_we) begin
            if (exp_w_q.size() == 0) check("gpio_we_unexpected", 64'd1, 64'd0);
            else check("gpio_wdata", 64'(gpio_wdata), 64'(exp_w_q.pop_front()));
        end
        if (gpio_re) begin
            re_count++;
            check("gpio_re_width", 64'(re_prev), 64'd0);
        end
        re_prev = gpio_re;
    end

    initial begin
        int rsp_before;
        logic [2:0] grants3 [4];
        int got_n;
        logic [31:0] first_wd3;
        bit seen_wd3;

        reset = 1'b1; reset3 = 1'b1;
        r3_valid = '0; r3_write = '0; r3_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_gpio_we_re", 64'({gpio_we, gpio_re}), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_gpio_wdata", 64'(gpio_wdata), 64'd0);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);

        // Single write from req0, single read from req1.
        expect_rsp(0, 32'h0); exp_w_q.push_back(32'hDEAD_BEEF);
        add(0, 1'b1, 32'hDEAD_BEEF);
        wait_done("t1_write", 40);
        expect_rsp(1, 32'hDEAD_BEEF);
        add(1, 1'b0, 32'h0);
        wait_done("t2_read", 40);

        // Both continuously valid: alternating 0,1,0,1,0,1.
        for (int k = 1; k <= 3; k++) begin
            exp_w_q.push_back(32'h11 * k);
            expect_rsp(0, 32'h0);
            expect_rsp(1, 32'h11 * k);
            add(0, 1'b1, 32'h11 * k);
            add(1, 1'b0, 32'h0);
        end
        wait_done("t3_alternate", 100);

        // req1 alone, req0 shows up mid-transaction and wins next on the pointer.
        expect_rsp(1, 32'h33); expect_rsp(0, 32'h0); expect_rsp(1, 32'h44);
        exp_w_q.push_back(32'h44);
        add(1, 1'b0, 32'h0); add(1, 1'b0, 32'h0);
        wait_busy("t4");
        add(0, 1'b1, 32'h44);
        wait_done("t4_late_req0", 60);

        // Leave rr_ptr at 1, then abort a req1 read in CAPTURE.
        expect_rsp(0, 32'h0); exp_w_q.push_back(32'h55);
        add(0, 1'b1, 32'h55);
        wait_done("t5_write", 40);
        add(1, 1'b0, 32'h0);
        wait_busy("t5_abort");
        check("abort_issue_re", 64'(gpio_re), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_outputs", 64'({rsp_valid, gpio_we, gpio_re, busy, req_ready}), 64'd0);
        check("abort_data", 64'({gpio_wdata, rsp_rdata}), 64'd0);
        rsp_before = rsp_count;
        acc_q.delete();
        repeat (4) @(negedge clk);
        check("abort_no_rsp", 64'(rsp_count), 64'(rsp_before));

        // Pointer back at 0: req0 wins first after the reset.
        expect_rsp(0, 32'h0); exp_w_q.push_back(32'h66); expect_rsp(1, 32'h66);
        add(0, 1'b1, 32'h66); add(1, 1'b0, 32'h0);
        wait_done("t6_after_reset", 60);
        check("gpio_re_count", 64'(re_count), 64'd8);

        // Three requesters, all valid writes: grants 0,1,2,0.
        got_n = 0; seen_wd3 = 1'b0; first_wd3 = '0;
        for (int k = 0; k < 4; k++) grants3[k] = '0;
        r3_valid = 3'b111; r3_write = 3'b111;
        r3_wdata = {32'hA2, 32'hA1, 32'hA0};
        reset3 = 1'b0;
        for (int k = 0; k < 60 && got_n < 4; k++) begin
            @(negedge clk);
            if (r3_rsp_valid != 3'b000) begin
                grants3[got_n] = r3_rsp_valid;
                got_n++;
            end
            if (g3_we && !seen_wd3) begin
                first_wd3 = g3_wdata;
                seen_wd3 = 1'b1;
            end
        end
        check("n3_grant0", 64'(grants3[0]), 64'd1);
        check("n3_grant1", 64'(grants3[1]), 64'd2);
        check("n3_grant2", 64'(grants3[2]), 64'd4);
        check("n3_grant3_wrap", 64'(grants3[3]), 64'd1);
        check("n3_first_wdata", 64'(first_wd3), 64'hA0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
